bdi_compressor_pipe: RTL

BDI_COMPRESSOR_PIPE -- requirements
Module: bdi_compressor_pipe

---
 rtl/bdi_compressor_pipe.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/bdi_compressor_pipe.sv
// bdi_compressor_pipe: multi-cycle base-delta-immediate line compressor (IDLE/EVAL/PACK/DONE).
// Define BDI_ZERO_REP_EN to enable the ZERO and REP8 candidates; otherwise their slots never fit.
module bdi_compressor_pipe #(
    parameter int LINE_BYTES = 32
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*LINE_BYTES-1:0] in_line,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*LINE_BYTES-1:0] out_data,
    output logic [3:0]              out_enc,
    output logic [6:0]              out_size,
    output logic                    busy
);
    localparam int W = 8 * LINE_BYTES;
    localparam logic [6:0] SZ_B8D1 = 7'(8 + LINE_BYTES / 8);
    localparam logic [6:0] SZ_B8D2 = 7'(8 + LINE_BYTES / 4);
    localparam logic [6:0] SZ_B8D4 = 7'(8 + LINE_BYTES / 2);
    localparam logic [6:0] SZ_B4D1 = 7'(4 + LINE_BYTES / 4);
    localparam logic [6:0] SZ_B4D2 = 7'(4 + LINE_BYTES / 2);
    localparam logic [6:0] SZ_B2D1 = 7'(2 + LINE_BYTES / 2);

    typedef enum logic [1:0] {IDLE, EVAL, PACK, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   line_q, line_d, data_q, data_d, pack_data;
    logic [3:0]     idx_q, idx_d, best_enc_q, best_enc_d, enc_q, enc_d;
    logic [6:0]     best_size_q, best_size_d, size_q, size_d, cand_size;
    logic           zero_fit, rep_fit, cand_fit;

    // Deltas are taken modulo 2^(8b) and must sign-fit in 8d bits.
    function automatic logic bd_fit(input logic [W-1:0] l, input int b, input int d);
        logic [63:0] m, lim, base, delta;
        logic [W-1:0] sh;
        m = (64'd1 << (8 * b)) - 64'd1;
        lim = 64'd1 << (8 * d - 1);
        base = l[63:0] & m;
        bd_fit = 1'b1;
        for (int i = 1; i < LINE_BYTES / b; i++) begin
            sh = l >> (8 * b * i);
            delta = (sh[63:0] - base) & m;
            bd_fit = bd_fit & (delta < lim || delta > m - lim);
        end
    endfunction

    function automatic logic [W-1:0] bd_pack(input logic [W-1:0] l, input int b, input int d);
        logic [63:0] m, dm, base, delta;
        logic [W-1:0] sh;
        m = (64'd1 << (8 * b)) - 64'd1;
        dm = (64'd1 << (8 * d)) - 64'd1;
        base = l[63:0] & m;
        bd_pack = W'(base);
        for (int i = 0; i < LINE_BYTES / b; i++) begin
            sh = l >> (8 * b * i);
            delta = (sh[63:0] - base) & m;
            bd_pack = bd_pack | (W'(delta & dm) << (8 * b + 8 * d * i));
        end
    endfunction

`ifdef BDI_ZERO_REP_EN
    assign zero_fit = line_q == '0;
    always_comb begin
        rep_fit = 1'b1;
        for (int i = 1; i < LINE_BYTES / 8; i++)
            rep_fit = rep_fit & (line_q[64*i +: 64] == line_q[63:0]);
    end
`else
    assign zero_fit = 1'b0;
    assign rep_fit  = 1'b0;
`endif

    always_comb begin
        cand_fit  = idx_q == 4'd1 ? zero_fit :
                    idx_q == 4'd2 ? rep_fit :
                    idx_q == 4'd3 ? bd_fit(line_q, 8, 1) :
                    idx_q == 4'd4 ? bd_fit(line_q, 8, 2) :
                    idx_q == 4'd5 ? bd_fit(line_q, 8, 4) :
                    idx_q == 4'd6 ? bd_fit(line_q, 4, 1) :
                    idx_q == 4'd7 ? bd_fit(line_q, 4, 2) :
                    idx_q == 4'd8 ? bd_fit(line_q, 2, 1) : 1'b0;
        cand_size = idx_q == 4'd1 ? 7'd1 :
                    idx_q == 4'd2 ? 7'd8 :
                    idx_q == 4'd3 ? SZ_B8D1 :
                    idx_q == 4'd4 ? SZ_B8D2 :
                    idx_q == 4'd5 ? SZ_B8D4 :
                    idx_q == 4'd6 ? SZ_B4D1 :
                    idx_q == 4'd7 ? SZ_B4D2 : SZ_B2D1;
        pack_data = best_enc_q == 4'd1 ? '0 :
                    best_enc_q == 4'd2 ? W'(line_q[63:0]) :
                    best_enc_q == 4'd3 ? bd_pack(line_q, 8, 1) :
                    best_enc_q == 4'd4 ? bd_pack(line_q, 8, 2) :
                    best_enc_q == 4'd5 ? bd_pack(line_q, 8, 4) :
                    best_enc_q == 4'd6 ? bd_pack(line_q, 4, 1) :
                    best_enc_q == 4'd7 ? bd_pack(line_q, 4, 2) :
                    best_enc_q == 4'd8 ? bd_pack(line_q, 2, 1) : line_q;
    end

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        idx_d       = idx_q;
        best_enc_d  = best_enc_q;
        best_size_d = best_size_q;
        data_d      = data_q;
        enc_d       = enc_q;
        size_d      = size_q;
        if (state_q == IDLE && in_valid) begin
            line_d      = in_line;
            idx_d       = 4'd1;
            best_enc_d  = 4'd0;
            best_size_d = 7'(LINE_BYTES);
            state_d     = EVAL;
        end else if (state_q == EVAL) begin
            // Strictly smaller only, so ties keep the lower code.
            if (cand_fit && cand_size < best_size_q) begin
                best_enc_d  = idx_q;
                best_size_d = cand_size;
            end
            idx_d   = idx_q + 4'd1;
            state_d = idx_q == 4'd8 ? PACK : EVAL;
        end else if (state_q == PACK) begin
            data_d  = pack_data;
            enc_d   = best_enc_q;
            size_d  = best_size_q;
            state_d = DONE;
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            line_q      <= '0;
            idx_q       <= '0;
            best_enc_q  <= '0;
            best_size_q <= '0;
            data_q      <= '0;
            enc_q       <= '0;
            size_q      <= '0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            idx_q       <= idx_d;
            best_enc_q  <= best_enc_d;
            best_size_q <= best_size_d;
            data_q      <= data_d;
            enc_q       <= enc_d;
            size_q      <= size_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign out_data  = data_q;
    assign out_enc   = enc_q;
    assign out_size  = size_q;
endmodule
